mem_stage_sram: RTL
===================

Name: mem_stage_sram

Overview:
- Parametrised successor to the pipeline MEM stage: the single-cycle internal data memory is replaced by a request/acknowledge port to an external, variable-latency SRAM controller.
- Sits between the EX/MEM and MEM/WB pipeline registers.
- Control, destination, PC and ALU result pass straight through.
- Loads and stores are sequenced by a small FSM that drives a pipeline-wide stall until the access completes or times out.
- Adds an address range check with an error flag.

Parameters:
- DATA_W, 32, data/ALU/PC width
- BASE_ADDR, 1024, byte address subtracted from ALU result to form memory offset
- DEPTH_BYTES, 256, size of the addressable window; offsets >= this are out of range
- TIMEOUT, 15, max cycles in BUSY waiting for mem_ack before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- MEM_W_EN  in  1  store request
- MEM_R_EN  in  1  load request
- WB_EN  in  1  writeback enable, passed through
- ALU_result_in  in  DATA_W  effective byte address / ALU value
- PC  in  DATA_W  passed through
- val_Rm  in  DATA_W  store data
- Dest_in  in  4  destination register
- mem_ack  in  1  SRAM controller completion pulse
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- Dest_out, WB_EN_out, MEM_R_EN_out, PC_out, ALU_result  out  4/1/1/DATA_W/DATA_W  combinational pass-throughs
- data  out  DATA_W  registered load result
- mem_req  out  1  request to SRAM
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  ALU_result_in - BASE_ADDR, registered
- mem_wdata  out  DATA_W  registered store data
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- addr_err  out  1  one-cycle pulse: out-of-range access or timeout

Behaviour:
- Reset (rst=0, any time): state=IDLE, timeout counter=0, and the following outputs are 0: data, mem_req, mem_we, mem_addr, mem_wdata, addr_err. stall is 0 in IDLE with no access pending. A reset mid-access abandons the request; mem_req drops immediately.
- Access condition: acc = MEM_R_EN | MEM_W_EN. If both are set, treat as a write (write priority).
- Offset: off = ALU_result_in - BASE_ADDR, computed modulo 2^DATA_W. An access is in range iff off < DEPTH_BYTES as unsigned. Underflow wraps to a large value and is therefore out of range.
- IDLE, no access: stall=0, no request.
- IDLE, acc and in range:
  - stall=1 combinationally.
  - On the clock edge: capture mem_addr=off, mem_wdata=val_Rm, mem_we=MEM_W_EN; go to BUSY.
- IDLE, acc and out of range:
  - stall=0, no request.
  - Next edge: addr_err=1 for one cycle; data is forced to 0 on a load.
- BUSY:
  - mem_req=1; stall=1; mem_addr, mem_wdata and mem_we are held stable.
  - Counter increments each cycle.
  - On mem_ack: if read, data<=mem_rdata; go to DONE.
  - If the counter reaches TIMEOUT with no ack: drop mem_req, pulse addr_err, data<=0 on a read, go to DONE.
- DONE: stall=0 and mem_req=0. The pipeline advances on this edge; next state is IDLE. No new access is issued while in DONE.
- Minimum latency: acc seen at cycle t, mem_req high from t+1, ack at t+1, data valid and stall low at t+2. Stall is high for 2 cycles per access.
- mem_ack outside BUSY is ignored.
- data holds its last value across stores and non-memory instructions.

Decomposition:
- Shared package mem_pkg:
  - state enum typedef {IDLE, BUSY, DONE}
  - default BASE_ADDR and DEPTH_BYTES constants
  - SRAM request struct (req, we, addr, wdata)
- One natural sub-module, mem_timeout_cnt: a loadable up-counter with terminal-count flag, cleared on entering BUSY.

Test Plan:
- Reset mid-BUSY (rst low while mem_req=1) -> mem_req, stall, data, addr_err all 0 asynchronously; state IDLE after release.
- Load: MEM_R_EN=1, ALU_result_in=1028, ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=4, mem_we=0, stall high 2 cycles, data=0xDEADBEEF in DONE.
- Store with 5-cycle ack delay: MEM_W_EN=1, ALU_result_in=1024+8, val_Rm=0x12345678 -> mem_we=1, mem_addr=8, mem_wdata=0x12345678 stable throughout, stall high 6 cycles, data unchanged.
- Out-of-range load: ALU_result_in=1000 (wraps) and ALU_result_in=1024+256 -> no mem_req, stall never high, addr_err pulses 1 cycle, data=0.
- Timeout: load at 1024 with no ack, TIMEOUT=15 -> mem_req high exactly 15 cycles, then addr_err pulse, data=0, stall released; a late mem_ack is ignored.
- Simultaneous MEM_R_EN=MEM_W_EN=1 at 1032 -> treated as write (mem_we=1). Pass-throughs (Dest_out, PC_out, WB_EN_out, ALU_result) equal their inputs in every cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, default window and SRAM request layout for the SRAM-backed MEM stage.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    localparam int BASE_ADDR_DEF = 1024;
    localparam int DEPTH_BYTES_DEF = 256;
    localparam int SRAM_W = 32;
    typedef struct packed {
        logic              req;
        logic              we;
        logic [SRAM_W-1:0] addr;
        logic [SRAM_W-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: BUSY-cycle counter; tc_o marks the last cycle allowed before aborting.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign tc_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: MEM stage talking to a variable-latency SRAM controller, stalling the pipeline
// until the access completes, times out, or is rejected as out of range.
module mem_stage_sram
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BASE_ADDR   = BASE_ADDR_DEF,
    parameter int DEPTH_BYTES = DEPTH_BYTES_DEF,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_W_EN,
    input  logic              MEM_R_EN,
    input  logic              WB_EN,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] val_Rm,
    input  logic [3:0]        Dest_in,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        Dest_out,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              addr_err
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d, addr_q, addr_d, wdata_q, wdata_d, off;
    logic              we_q, we_d, err_q, err_d, acc, in_rng, tc;
    assign Dest_out     = Dest_in;
    assign WB_EN_out    = WB_EN;
    assign MEM_R_EN_out = MEM_R_EN;
    assign PC_out       = PC;
    assign ALU_result   = ALU_result_in;
    // Underflowing addresses wrap to huge offsets and fall out of range naturally.
    assign off    = ALU_result_in - DATA_W'(BASE_ADDR);
    assign in_rng = off < DATA_W'(DEPTH_BYTES);
    assign acc    = MEM_R_EN | MEM_W_EN;
    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_q == IDLE),
        .en_i (state_q == BUSY),
        .tc_o (tc)
    );
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: if (acc && in_rng) begin
                stall   = 1'b1;
                we_d    = MEM_W_EN;
                addr_d  = off;
                wdata_d = val_Rm;
                state_d = BUSY;
            end else if (acc) begin
                err_d  = 1'b1;
                data_d = MEM_W_EN ? data_q : '0;
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack || tc) begin
                    err_d   = !mem_ack;
                    data_d  = we_q ? data_q : mem_ack ? mem_rdata : '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    assign data      = data_q;
    assign mem_req   = state_q == BUSY;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign addr_err  = err_q;
endmodule
